// File: rtl/npu_result_reader.sv
// NPU result reader: pops hi/lo byte pairs from the NPU output FIFO,
// rebuilds 16-bit results and hands them to the host over valid/ready.
module npu_result_reader #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLKEXT,
  input  logic             RST_GLO,
  input  logic             EN,
  input  logic             CLR,
  input  logic             FIFO_EMPTY,
  input  logic [7:0]       fifo_data_out,
  output logic             fifo_rd_en,
  output logic [15:0]      RES_DATA,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [CNT_W-1:0] RES_CNT,
  output logic             ORPHAN,
  output logic             BUSY
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    CAP_HI,
    REQ_LO,
    CAP_LO,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      res_q, res_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             orphan_q, orphan_d;

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      res_q    <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      res_q    <= res_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    res_d      = res_q;
    tmo_d      = tmo_q;
    cnt_d      = cnt_q;
    orphan_d   = orphan_q;
    fifo_rd_en = 1'b0;
    if (CLR) begin
      // abort wins over any pop or handshake in flight
      state_d  = IDLE;
      cnt_d    = '0;
      orphan_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (EN) state_d = REQ_HI;
        end
        REQ_HI: begin
          if (!EN) begin
            state_d = IDLE;
          end else if (!FIFO_EMPTY) begin
            fifo_rd_en = 1'b1;
            state_d    = CAP_HI;
          end
        end
        CAP_HI: begin
          hi_d    = fifo_data_out;
          tmo_d   = '0;
          state_d = REQ_LO;
        end
        REQ_LO: begin
          if (!FIFO_EMPTY) begin
            fifo_rd_en = 1'b1;
            state_d    = CAP_LO;
          end else if (tmo_q == TMO_LAST) begin
            // low byte never came: drop the high byte
            orphan_d = 1'b1;
            hi_d     = '0;
            tmo_d    = '0;
            state_d  = REQ_HI;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        CAP_LO: begin
          res_d   = {hi_q, fifo_data_out};
          state_d = OUT;
        end
        OUT: begin
          if (RES_READY) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = EN ? REQ_HI : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign RES_DATA  = res_q;
  assign RES_VALID = (state_q == OUT);
  assign RES_CNT   = cnt_q;
  assign ORPHAN    = orphan_q;
  assign BUSY      = (state_q != IDLE);

endmodule
